// File: rtl/pit_prescale_if.sv
// Control/strobe bundle between the PIT register block and the prescaler.
// The master drives the run controls and the rollover feedback; the slave returns the strobe, enable and shadowed divisor.
interface pit_prescale_if #(
  parameter int COUNT_SIZE = 16
);
  logic                  sync_reset;
  logic                  pit_enable;
  logic                  pit_slave;
  logic                  ext_sync_i;
  logic [3:0]            pre_sel;
  logic [COUNT_SIZE-1:0] mod_value_i;
  logic                  pit_roll_i;
  logic                  prescale_out;
  logic                  counter_sync;
  logic [COUNT_SIZE-1:0] mod_value_o;
  logic                  pit_busy;

  modport master (
    output sync_reset, pit_enable, pit_slave, ext_sync_i, pre_sel, mod_value_i, pit_roll_i,
    input  prescale_out, counter_sync, mod_value_o, pit_busy
  );

  modport slave (
    input  sync_reset, pit_enable, pit_slave, ext_sync_i, pre_sel, mod_value_i, pit_roll_i,
    output prescale_out, counter_sync, mod_value_o, pit_busy
  );
endinterface

// File: rtl/pit_prescale.sv
// PIT start FSM and 2^n prescaler: one-cycle increment strobe every 2^pre_sel RUN cycles, first on the 2^pre_sel-th.
// Outputs decode registered state only (no combinational input paths); there is no backpressure, the strobe is free-running in RUN.
module pit_prescale #(
  parameter int COUNT_SIZE = 16,
  parameter int PRE_WIDTH  = 15
) (
  input  logic           bus_clk,
  input  logic           async_rst_b,
  pit_prescale_if.slave  pit
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t                state, state_nxt;
  logic [PRE_WIDTH-1:0]  pre_cnt, pre_cnt_nxt, pre_term;
  logic [3:0]            pre_sel_r, pre_sel_clamp;
  logic                  ext_sync_d;
  logic                  ext_rise;
  logic [COUNT_SIZE-1:0] mod_value_r;

  assign ext_rise      = pit.ext_sync_i & ~ext_sync_d;
  assign pre_sel_clamp = (int'(pit.pre_sel) > PRE_WIDTH) ? 4'(PRE_WIDTH) : pit.pre_sel;

  // Terminal count 2^pre_sel_r-1 is just the low pre_sel_r bits set.
  always_comb begin
    pre_term = '0;
    for (int i = 0; i < PRE_WIDTH; i++) begin
      pre_term[i] = (i < int'(pre_sel_r));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pit.pit_enable) state_nxt = pit.pit_slave ? ARM : RUN;
      ARM: begin
        if (!pit.pit_enable)  state_nxt = IDLE;
        else if (ext_rise)    state_nxt = RUN;
      end
      RUN:  if (!pit.pit_enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (pit.sync_reset) state_nxt = IDLE;
  end

  // Counter only advances while staying in RUN, so it is already 0 on exit.
  always_comb begin
    pre_cnt_nxt = '0;
    if (state == RUN && state_nxt == RUN) begin
      pre_cnt_nxt = (pre_cnt == pre_term) ? '0 : pre_cnt + PRE_WIDTH'(1);
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!async_rst_b) begin
      state       <= IDLE;
      pre_cnt     <= '0;
      pre_sel_r   <= '0;
      ext_sync_d  <= 1'b0;
      mod_value_r <= '0;
    end else begin
      state      <= state_nxt;
      pre_cnt    <= pre_cnt_nxt;
      ext_sync_d <= pit.ext_sync_i;
      if (state != RUN) pre_sel_r <= pre_sel_clamp;
      // In RUN the divisor only changes at a period boundary.
      if (state != RUN || pit.pit_roll_i) mod_value_r <= pit.mod_value_i;
    end
  end

  assign pit.prescale_out = (state == RUN) && (pre_cnt == pre_term);
  assign pit.counter_sync = (state == RUN);
  assign pit.pit_busy     = (state != IDLE);
  assign pit.mod_value_o  = mod_value_r;

endmodule

// File: tb/tb_pit_prescale.sv
// Directed bench for pit_prescale: cycle table plus slave-wait and clamp/period sequences.
module tb_pit_prescale;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        bus_clk = 1'b0;
  logic        async_rst_b;
  logic        sync_reset, pit_enable, pit_slave, ext_sync_i, pit_roll_i;
  logic [3:0]  pre_sel;
  logic [15:0] mod_value_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 bus_clk = ~bus_clk;

  pit_prescale_if #(.COUNT_SIZE(16)) pit_big ();
  pit_prescale_if #(.COUNT_SIZE(16)) pit_small ();

  assign pit_big.sync_reset    = sync_reset;
  assign pit_big.pit_enable    = pit_enable;
  assign pit_big.pit_slave     = pit_slave;
  assign pit_big.ext_sync_i    = ext_sync_i;
  assign pit_big.pre_sel       = pre_sel;
  assign pit_big.mod_value_i   = mod_value_i;
  assign pit_big.pit_roll_i    = pit_roll_i;
  assign pit_small.sync_reset  = sync_reset;
  assign pit_small.pit_enable  = pit_enable;
  assign pit_small.pit_slave   = pit_slave;
  assign pit_small.ext_sync_i  = ext_sync_i;
  assign pit_small.pre_sel     = pre_sel;
  assign pit_small.mod_value_i = mod_value_i;
  assign pit_small.pit_roll_i  = pit_roll_i;

  pit_prescale #(.COUNT_SIZE(16), .PRE_WIDTH(15)) u_big (
    .bus_clk     (bus_clk),
    .async_rst_b (async_rst_b),
    .pit         (pit_big)
  );

  pit_prescale #(.COUNT_SIZE(16), .PRE_WIDTH(4)) u_small (
    .bus_clk     (bus_clk),
    .async_rst_b (async_rst_b),
    .pit         (pit_small)
  );

  typedef struct {
    logic        rst_b, srst, en, slave, ext;
    logic [3:0]  pre;
    logic [15:0] mod_i;
    logic        roll;
    logic        ps, cs, busy;
    logic [15:0] mod_o;
  } vec_t;

  vec_t vt [31];

  task automatic step();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
  endtask

  task automatic drive(input logic rb, input logic sr, input logic en, input logic sl,
                       input logic ex, input logic [3:0] ps, input logic [15:0] mi, input logic rl);
    async_rst_b = rb; sync_reset = sr; pit_enable = en; pit_slave = sl;
    ext_sync_i = ex; pre_sel = ps; mod_value_i = mi; pit_roll_i = rl;
  endtask

  initial begin
    int first_big, first_small, second_small;

    drive(L, L, L, L, L, 4'd0, 16'd0, L);

    //        rst srst en slv ext pre  mod_i   roll   ps cs busy mod_o
    vt[0]  = '{L, L, L, L, L, 4'd2, 16'd10, L,  L, L, L, 16'd0};
    vt[1]  = '{H, L, L, L, L, 4'd2, 16'd10, L,  L, L, L, 16'd10};
    vt[2]  = '{H, L, H, L, L, 4'd2, 16'd10, L,  L, H, H, 16'd10};
    vt[3]  = '{H, L, H, L, L, 4'd2, 16'd10, L,  L, H, H, 16'd10};
    vt[4]  = '{H, L, H, L, L, 4'd2, 16'd10, L,  L, H, H, 16'd10};
    vt[5]  = '{H, L, H, L, L, 4'd2, 16'd10, L,  H, H, H, 16'd10};
    vt[6]  = '{H, L, H, L, L, 4'd3, 16'd20, L,  L, H, H, 16'd10};
    vt[7]  = '{H, L, H, L, L, 4'd3, 16'd20, L,  L, H, H, 16'd10};
    vt[8]  = '{H, L, H, L, L, 4'd3, 16'd20, L,  L, H, H, 16'd10};
    vt[9]  = '{H, L, H, L, L, 4'd3, 16'd20, L,  H, H, H, 16'd10};
    vt[10] = '{H, L, H, L, L, 4'd3, 16'd20, H,  L, H, H, 16'd20};
    vt[11] = '{H, L, H, L, L, 4'd3, 16'd20, L,  L, H, H, 16'd20};
    vt[12] = '{H, L, H, L, L, 4'd3, 16'd20, L,  L, H, H, 16'd20};
    vt[13] = '{H, L, L, L, L, 4'd3, 16'd20, L,  L, L, L, 16'd20};
    vt[14] = '{H, L, L, L, L, 4'd3, 16'd30, H,  L, L, L, 16'd30};
    vt[15] = '{H, L, H, H, H, 4'd0, 16'd30, L,  L, L, H, 16'd30};
    vt[16] = '{H, L, H, H, H, 4'd0, 16'd30, L,  L, L, H, 16'd30};
    vt[17] = '{H, L, H, H, L, 4'd0, 16'd30, L,  L, L, H, 16'd30};
    vt[18] = '{H, L, H, H, H, 4'd0, 16'd30, L,  H, H, H, 16'd30};
    vt[19] = '{H, L, H, H, L, 4'd2, 16'd40, L,  H, H, H, 16'd30};
    vt[20] = '{H, L, H, H, L, 4'd2, 16'd40, L,  H, H, H, 16'd30};
    vt[21] = '{H, H, H, H, L, 4'd2, 16'd40, L,  L, L, L, 16'd30};
    vt[22] = '{H, L, L, L, L, 4'd2, 16'd40, L,  L, L, L, 16'd40};
    vt[23] = '{H, L, H, H, L, 4'd2, 16'd40, L,  L, L, H, 16'd40};
    vt[24] = '{H, L, H, H, L, 4'd2, 16'd40, L,  L, L, H, 16'd40};
    vt[25] = '{H, H, H, H, H, 4'd2, 16'd40, L,  L, L, L, 16'd40};
    vt[26] = '{H, L, L, L, L, 4'd2, 16'd40, L,  L, L, L, 16'd40};
    vt[27] = '{H, L, H, L, L, 4'd1, 16'd40, L,  L, H, H, 16'd40};
    vt[28] = '{H, L, H, L, L, 4'd1, 16'd40, L,  H, H, H, 16'd40};
    vt[29] = '{L, L, H, L, L, 4'd1, 16'd40, L,  L, L, L, 16'd0};
    vt[30] = '{H, L, L, L, L, 4'd1, 16'd50, L,  L, L, L, 16'd50};

    for (int i = 0; i < 31; i++) begin
      drive(vt[i].rst_b, vt[i].srst, vt[i].en, vt[i].slave, vt[i].ext,
            vt[i].pre, vt[i].mod_i, vt[i].roll);
      step();
      chk("prescale_out", i, 32'(pit_big.prescale_out), 32'(vt[i].ps));
      chk("counter_sync", i, 32'(pit_big.counter_sync), 32'(vt[i].cs));
      chk("pit_busy",     i, 32'(pit_big.pit_busy),     32'(vt[i].busy));
      chk("mod_value_o",  i, 32'(pit_big.mod_value_o),  32'(vt[i].mod_o));
    end

    // Slave start: long wait in ARM, then a single ext pulse.
    drive(L, L, L, L, L, 4'd2, 16'd5, L);
    step();
    drive(H, L, H, H, L, 4'd2, 16'd5, L);
    for (int c = 0; c < 11; c++) begin
      step();
      chk("arm_wait_busy", c, 32'(pit_big.pit_busy), 32'd1);
      chk("arm_wait_cs",   c, 32'(pit_big.counter_sync), 32'd0);
    end
    ext_sync_i = H;
    step();
    chk("slave_run_cs", 0, 32'(pit_big.counter_sync), 32'd1);
    ext_sync_i = L;
    pit_enable = L;
    step();
    chk("slave_stop_busy", 0, 32'(pit_big.pit_busy), 32'd0);

    // Clamp: pre_sel=15 gives 32768 on the wide instance, 16 on the PRE_WIDTH=4 one.
    drive(L, L, L, L, L, 4'd15, 16'd0, L);
    step();
    drive(H, L, L, L, L, 4'd15, 16'd0, L);
    step();
    pit_enable = H;
    step();
    first_big = 0; first_small = 0; second_small = 0;
    for (int c = 1; c <= 32770; c++) begin
      if (pit_big.prescale_out && first_big == 0) first_big = c;
      if (pit_small.prescale_out) begin
        if (first_small == 0)       first_small = c;
        else if (second_small == 0) second_small = c;
      end
      step();
    end
    chk("period_w15_first",  0, 32'(first_big),    32'd32768);
    chk("period_w4_first",   0, 32'(first_small),  32'd16);
    chk("period_w4_second",  0, 32'(second_small), 32'd32);
    pit_enable = L;
    step();
    chk("clamp_stop_ps", 0, 32'(pit_big.prescale_out), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/pit_prescale.md
PIT_PRESCALE -- requirements
Module: pit_prescale

Interface
REQ-001 Parameter COUNT_SIZE, default 16, SHALL set the width of the modulo value path.
REQ-002 Parameter PRE_WIDTH, default 15, SHALL set the prescaler counter width; maximum division 2^PRE_WIDTH.
REQ-003 bus_clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 async_rst_b  input  1  reset, synchronous and active-low, sampled only on rising bus_clk.
REQ-005 sync_reset  input  1  active-high soft reset.
REQ-006 pit_enable  input  1  run request.
REQ-007 pit_slave  input  1  1 = start waits for an ext_sync_i rising edge.
REQ-008 ext_sync_i  input  1  external start strobe, synchronous to bus_clk.
REQ-009 pre_sel  input  4  prescale select; divide by 2^pre_sel.
REQ-010 mod_value_i  input  COUNT_SIZE  software modulo divisor.
REQ-011 pit_roll_i  input  1  rollover pulse fed back from the downstream modulo counter.
REQ-012 prescale_out  output  1  one-cycle increment strobe to the modulo counter.
REQ-013 counter_sync  output  1  counter enable; low clears the downstream counter.
REQ-014 mod_value_o  output  COUNT_SIZE  shadowed divisor to the modulo counter.
REQ-015 pit_busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ARM and RUN; counter_sync SHALL be 1 only in RUN; pit_busy SHALL be 1 in ARM and RUN.
REQ-017 IDLE: pit_enable=1 and sync_reset=0 -> ARM if pit_slave=1, else -> RUN, both on the next edge; pit_slave SHALL be sampled only in IDLE.
REQ-018 ARM: a rising edge of ext_sync_i (ext_sync_i=1 while the registered previous value ext_sync_d=0) -> RUN on the next edge; an edge occurring in the IDLE->ARM transition cycle SHALL NOT count.
REQ-019 ext_sync_d SHALL be updated every cycle in every state.
REQ-020 ARM or RUN with pit_enable=0 -> IDLE on the next edge.
REQ-021 sync_reset=1 in any state SHALL force IDLE on the next edge, clear pre_cnt, and take priority over pit_enable, ext_sync_i and pit_roll_i.
REQ-022 pre_sel_r SHALL load from pre_sel every cycle in IDLE and ARM; pre_sel changes SHALL be ignored while in RUN.
REQ-023 A pre_sel value greater than PRE_WIDTH SHALL be clamped to PRE_WIDTH when loaded.
REQ-024 pre_cnt (PRE_WIDTH bits) SHALL be 0 in IDLE and ARM.
REQ-025 In RUN, pre_cnt SHALL increment every cycle and wrap to 0 in the cycle after reaching terminal value 2^pre_sel_r-1.
REQ-026 prescale_out SHALL be a decode of registered state only: 1 exactly when state=RUN and pre_cnt=2^pre_sel_r-1, otherwise 0.
REQ-027 Strobe timing SHALL be: first prescale_out on the 2^pre_sel_r-th RUN cycle, then every 2^pre_sel_r cycles; with pre_sel_r=0 it is high on every RUN cycle.
REQ-028 mod_value_o SHALL load mod_value_i every cycle in IDLE and ARM.
REQ-029 In RUN, mod_value_o SHALL load mod_value_i only in cycles where pit_roll_i=1, so a divisor change takes effect at a period boundary.
REQ-030 pit_roll_i SHALL be ignored outside RUN.
REQ-031 Leaving RUN SHALL drop prescale_out and counter_sync in the same cycle that state becomes IDLE, with no trailing strobe.

Reset
REQ-032 async_rst_b=0 at a rising edge SHALL set: state=IDLE, pre_cnt=0, pre_sel_r=0, ext_sync_d=0, mod_value_o=0.
REQ-033 During reset, outputs SHALL be prescale_out=0, counter_sync=0, pit_busy=0.
REQ-034 Reset SHALL override sync_reset and every other input.
REQ-035 Reset asserted mid-RUN SHALL stop strobes from the following cycle.

Verification
REQ-036 Master start: pit_slave=0, pre_sel=2, pit_enable 0->1 -> RUN next edge; counter_sync=1; prescale_out on RUN cycles 4, 8, 12.
REQ-037 Slave start: pit_slave=1, pit_enable=1, ext_sync_i held 0 for 10 cycles, then pulsed -> pit_busy=1 and counter_sync=0 throughout the wait; RUN on the edge after the pulse.
REQ-038 Clamp and bypass: pre_sel=0 -> prescale_out high every RUN cycle; pre_sel=15 with PRE_WIDTH=15 -> period 32768; pre_sel=15 with PRE_WIDTH=4 -> period 16.
REQ-039 Shadowing: in RUN, change mod_value_i 10->20 and pre_sel 2->3 -> mod_value_o stays 10 until the pit_roll_i pulse, then 20; prescale period stays 4.
REQ-040 Stop and abort: pit_enable=0 mid-period -> IDLE next edge with no strobe; sync_reset=1 together with an ext_sync_i edge in ARM -> IDLE.
REQ-041 Reset mid-RUN: async_rst_b=0 -> all REQ-032/REQ-033 values at the next edge.
